// File: rtl/imm_gen_pkg.sv
// Shared constants for the immediate/target generator stage.
// Holds the opcode map, the result-kind encoding, buffer states and default widths.
package imm_gen_pkg;

    localparam int DEF_WORD_SIZE    = 16;
    localparam int DEF_OPCODE_WIDTH = 4;
    localparam int DEF_IMM_WIDTH    = 8;
    localparam int DEF_TGT_WIDTH    = 12;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;

    typedef enum logic [2:0] {
        KIND_NONE   = 3'd0,
        KIND_SEXT   = 3'd1,
        KIND_ZEXT   = 3'd2,
        KIND_LHI    = 3'd3,
        KIND_BRANCH = 3'd4,
        KIND_JUMP   = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_gen_if.sv
// Decode-side and execute-side valid/ready channels of the immediate generator stage.
// The stage uses the slave modport; the upstream/downstream environment uses master.
interface imm_gen_if #(parameter int WORD_SIZE = 16);
    import imm_gen_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_instr;
    logic [WORD_SIZE-1:0] in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_imm;
    logic [WORD_SIZE-1:0] out_br_target;
    logic [WORD_SIZE-1:0] out_jmp_target;
    kind_e                out_kind;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_br_target, out_jmp_target, out_kind
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_br_target, out_jmp_target, out_kind
    );

endinterface

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational opcode decode and immediate/branch/jump target generation.
// Macro IMM_GEN_LHI_SHIFT_EN: LHI immediate is pre-shifted into the upper bits.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
    parameter int TGT_WIDTH    = DEF_TGT_WIDTH
) (
    input  logic [WORD_SIZE-1:0] instr,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] imm,
    output logic [WORD_SIZE-1:0] br_target,
    output logic [WORD_SIZE-1:0] jmp_target,
    output kind_e                kind
);

    logic [OPCODE_WIDTH-1:0]    opcode;
    logic signed [IMM_WIDTH-1:0] imm_field;
    logic [TGT_WIDTH-1:0]       tgt_field;
    logic [WORD_SIZE-1:0]       imm_sext;
    logic [WORD_SIZE-1:0]       imm_zext;
    logic [WORD_SIZE-1:0]       imm_lhi;

    assign opcode    = instr[WORD_SIZE-1 -: OPCODE_WIDTH];
    assign imm_field = instr[IMM_WIDTH-1:0];
    assign tgt_field = instr[TGT_WIDTH-1:0];
    assign imm_sext  = WORD_SIZE'(imm_field);
    assign imm_zext  = WORD_SIZE'(unsigned'(imm_field));

`ifdef IMM_GEN_LHI_SHIFT_EN
    assign imm_lhi = imm_zext << (WORD_SIZE - IMM_WIDTH);
`else
    assign imm_lhi = imm_zext;
`endif

    // Both targets are produced for every opcode; execute picks by kind.
    assign br_target  = pc + WORD_SIZE'(1) + imm_sext;
    assign jmp_target = {pc[WORD_SIZE-1:TGT_WIDTH], tgt_field};

    always_comb begin
        imm  = '0;
        kind = KIND_NONE;
        case (opcode)
            OPCODE_WIDTH'(OP_ADI),
            OPCODE_WIDTH'(OP_LWD),
            OPCODE_WIDTH'(OP_SWD): begin
                imm  = imm_sext;
                kind = KIND_SEXT;
            end
            OPCODE_WIDTH'(OP_ORI): begin
                imm  = imm_zext;
                kind = KIND_ZEXT;
            end
            OPCODE_WIDTH'(OP_LHI): begin
                imm  = imm_lhi;
                kind = KIND_LHI;
            end
            OPCODE_WIDTH'(OP_BNE),
            OPCODE_WIDTH'(OP_BEQ),
            OPCODE_WIDTH'(OP_BGZ),
            OPCODE_WIDTH'(OP_BLZ): begin
                imm  = imm_sext;
                kind = KIND_BRANCH;
            end
            OPCODE_WIDTH'(OP_JMP),
            OPCODE_WIDTH'(OP_JAL): begin
                imm  = WORD_SIZE'(tgt_field);
                kind = KIND_JUMP;
            end
            default: begin
                imm  = '0;
                kind = KIND_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate/target stage with a 2-entry skid buffer between decode and execute.
// Macro IMM_GEN_LHI_SHIFT_EN (in imm_decode) selects pre-shifted LHI immediates.
//
// state    | meaning
// ST_EMPTY | nothing buffered, out_valid=0
// ST_ONE   | main register holds the presented result
// ST_TWO   | main presented, skid holds the next result, in_ready=0
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int WORD_SIZE    = DEF_WORD_SIZE,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int IMM_WIDTH    = DEF_IMM_WIDTH,
    parameter int TGT_WIDTH    = DEF_TGT_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    imm_gen_if.slave bus
);

    typedef struct packed {
        logic [WORD_SIZE-1:0] imm;
        logic [WORD_SIZE-1:0] br_target;
        logic [WORD_SIZE-1:0] jmp_target;
        kind_e                kind;
    } entry_t;

    buf_state_e state_q, state_d;
    entry_t     main_q, main_d, skid_q, skid_d, dec;
    logic       in_ready_q;
    logic       accept;

    logic [WORD_SIZE-1:0] dec_imm, dec_br, dec_jmp;
    kind_e                dec_kind;

    imm_decode #(
        .WORD_SIZE   (WORD_SIZE),
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .IMM_WIDTH   (IMM_WIDTH),
        .TGT_WIDTH   (TGT_WIDTH)
    ) u_decode (
        .instr     (bus.in_instr),
        .pc        (bus.in_pc),
        .imm       (dec_imm),
        .br_target (dec_br),
        .jmp_target(dec_jmp),
        .kind      (dec_kind)
    );

    assign dec    = '{imm: dec_imm, br_target: dec_br, jmp_target: dec_jmp, kind: dec_kind};
    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && bus.out_ready) begin
                    main_d = dec;
                end else if (accept) begin
                    skid_d  = dec;
                    state_d = ST_TWO;
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (bus.out_ready) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush overrides everything, including a same-cycle accept.
        if (flush) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_TWO);
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = (state_q != ST_EMPTY);
    assign bus.out_imm        = main_q.imm;
    assign bus.out_br_target  = main_q.br_target;
    assign bus.out_jmp_target = main_q.jmp_target;
    assign bus.out_kind       = main_q.kind;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed and scoreboarded checks for imm_gen_stage (default 16-bit configuration).
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    imm_gen_if #(.WORD_SIZE(16)) bus ();

    imm_gen_stage dut (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

`ifdef IMM_GEN_LHI_SHIFT_EN
    localparam logic [15:0] LHI_IMM = 16'hAB00;
`else
    localparam logic [15:0] LHI_IMM = 16'h00AB;
`endif

    localparam int NV = 13;
    logic [15:0] v_instr [NV] = '{16'h41F0, 16'h51F0, 16'h01FE, 16'h107F, 16'h9123, 16'h60AB, 16'hA800,
                                  16'hF0F0, 16'h7080, 16'h3001, 16'h8005, 16'h2080, 16'hB0FF};
    logic [15:0] v_pc    [NV] = '{16'h0010, 16'h0010, 16'h0005, 16'hFFF0, 16'hA000, 16'h1234, 16'h3456,
                                  16'h0000, 16'h0100, 16'hFFFF, 16'h0000, 16'h0000, 16'h2000};
    logic [15:0] v_imm   [NV] = '{16'hFFF0, 16'h00F0, 16'hFFFE, 16'h007F, 16'h0123, LHI_IMM, 16'h0800,
                                  16'h0000, 16'hFF80, 16'h0001, 16'h0005, 16'hFF80, 16'h0000};
    logic [15:0] v_br    [NV] = '{16'h0001, 16'h0001, 16'h0004, 16'h0070, 16'hA024, 16'h11E0, 16'h3457,
                                  16'hFFF1, 16'h0081, 16'h0001, 16'h0006, 16'hFF81, 16'h2000};
    logic [15:0] v_jmp   [NV] = '{16'h01F0, 16'h01F0, 16'h01FE, 16'hF07F, 16'hA123, 16'h10AB, 16'h3800,
                                  16'h00F0, 16'h0080, 16'hF001, 16'h0005, 16'h0080, 16'h20FF};
    logic [2:0]  v_kind  [NV] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd5, 3'd3, 3'd5,
                                  3'd0, 3'd1, 3'd4, 3'd1, 3'd4, 3'd0};

    typedef struct packed {
        logic [15:0] imm;
        logic [15:0] br;
        logic [15:0] jmp;
        logic [2:0]  kind;
    } exp_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic [15:0] pc);
        bus.in_instr = instr;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
    endtask

    function automatic exp_t ref_dec(input logic [15:0] instr, input logic [15:0] pc);
        exp_t        e;
        logic [15:0] s8;
        s8    = {{8{instr[7]}}, instr[7:0]};
        e.br  = pc + 16'd1 + s8;
        e.jmp = {pc[15:12], instr[11:0]};
        case (instr[15:12])
            4'd0, 4'd1, 4'd2, 4'd3: begin e.imm = s8;                    e.kind = 3'd4; end
            4'd4, 4'd7, 4'd8:       begin e.imm = s8;                    e.kind = 3'd1; end
            4'd5:                   begin e.imm = {8'h00, instr[7:0]};   e.kind = 3'd2; end
`ifdef IMM_GEN_LHI_SHIFT_EN
            4'd6:                   begin e.imm = {instr[7:0], 8'h00};   e.kind = 3'd3; end
`else
            4'd6:                   begin e.imm = {8'h00, instr[7:0]};   e.kind = 3'd3; end
`endif
            4'd9, 4'd10:            begin e.imm = {4'h0, instr[11:0]};   e.kind = 3'd5; end
            default:                begin e.imm = 16'h0000;              e.kind = 3'd0; end
        endcase
        return e;
    endfunction

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step(); step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_checks++; if (bus.out_imm !== 16'h0000) begin n_fail++; $display("FAIL reset_imm got %h want 0000", bus.out_imm); end
        n_checks++; if (bus.out_br_target !== 16'h0000) begin n_fail++; $display("FAIL reset_br got %h want 0000", bus.out_br_target); end
        n_checks++; if (bus.out_jmp_target !== 16'h0000) begin n_fail++; $display("FAIL reset_jmp got %h want 0000", bus.out_jmp_target); end
        n_checks++; if (bus.out_kind !== 3'd0) begin n_fail++; $display("FAIL reset_kind got %0d want 0", bus.out_kind); end
    endtask

    task automatic test_decode();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(v_instr[i], v_pc[i]);
            step();
            bus.in_valid = 1'b0;
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL decode_valid[%0d] got %b want 1", i, bus.out_valid); end
            n_checks++; if (bus.out_imm !== v_imm[i]) begin n_fail++; $display("FAIL decode_imm[%0d] got %h want %h", i, bus.out_imm, v_imm[i]); end
            n_checks++; if (bus.out_br_target !== v_br[i]) begin n_fail++; $display("FAIL decode_br[%0d] got %h want %h", i, bus.out_br_target, v_br[i]); end
            n_checks++; if (bus.out_jmp_target !== v_jmp[i]) begin n_fail++; $display("FAIL decode_jmp[%0d] got %h want %h", i, bus.out_jmp_target, v_jmp[i]); end
            n_checks++; if (bus.out_kind !== v_kind[i]) begin n_fail++; $display("FAIL decode_kind[%0d] got %0d want %0d", i, bus.out_kind, v_kind[i]); end
            step();
        end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL decode_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(16'h4011, 16'h0000);
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'h0011) begin n_fail++; $display("FAIL bp_first got v=%b imm=%h want v=1 imm=0011", bus.out_valid, bus.out_imm); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got %b want 1", bus.in_ready); end
        drive(16'h4022, 16'h0000);
        step();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_two got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_imm !== 16'h0011) begin n_fail++; $display("FAIL bp_hold1 got %h want 0011", bus.out_imm); end
        drive(16'h4033, 16'h0000);
        step();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'h0011) begin n_fail++; $display("FAIL bp_hold2 got v=%b imm=%h want v=1 imm=0011", bus.out_valid, bus.out_imm); end
        bus.out_ready = 1'b1;
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'h0022) begin n_fail++; $display("FAIL bp_second got v=%b imm=%h want v=1 imm=0022", bus.out_valid, bus.out_imm); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'h0033) begin n_fail++; $display("FAIL bp_third got v=%b imm=%h want v=1 imm=0033", bus.out_valid, bus.out_imm); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(16'h4011, 16'h0000);
        step();
        drive(16'h4022, 16'h0000);
        flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_one got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
        drive(16'h4011, 16'h0000);
        step();
        drive(16'h4022, 16'h0000);
        step();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_reach_two got %b want 0", bus.in_ready); end
        drive(16'h4033, 16'h0000);
        flush = 1'b1;
        step();
        flush = 1'b0; bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_two got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b1;
        drive(16'h4044, 16'h0000);
        step();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_imm !== 16'h0044) begin n_fail++; $display("FAIL flush_next got v=%b imm=%h want v=1 imm=0044", bus.out_valid, bus.out_imm); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leftover got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(16'h4055, 16'h0000);
        step();
        drive(16'h4066, 16'h0000);
        step();
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
        n_checks++; if (bus.out_imm !== 16'h0000 || bus.out_kind !== 3'd0) begin n_fail++; $display("FAIL rstmid_data got imm=%h kind=%0d want 0000/0", bus.out_imm, bus.out_kind); end
        step();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        step();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t act;
        int   sent = 0;
        int   cyc = 0;
        logic fired;
        bus.in_valid = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!bus.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                drive(16'($urandom), 16'($urandom));
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                act = '{imm: bus.out_imm, br: bus.out_br_target, jmp: bus.out_jmp_target, kind: bus.out_kind};
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious got imm=%h with empty scoreboard", bus.out_imm);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL rand_data got %h/%h/%h/%0d want %h/%h/%h/%0d",
                                 act.imm, act.br, act.jmp, act.kind, e.imm, e.br, e.jmp, e.kind);
                    end
                end
            end
            fired = bus.in_valid && bus.in_ready;
            if (fired) begin
                q.push_back(ref_dec(bus.in_instr, bus.in_pc));
                sent++;
            end
            step();
            cyc++;
            if (fired) bus.in_valid = 1'b0;
        end
        n_checks++; if (cyc >= 20000) begin n_fail++; $display("FAIL rand_timeout got sent=%0d pending=%0d want 1000/0", sent, q.size()); end
        bus.out_ready = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_tail got %b want 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
